// File: rtl/info_frame_pkg.sv
// Shared constants and types for the runtime-programmable InfoFrame builder.
// Header field widths, standard type codes and the builder's sequencing states.
package info_frame_pkg;

    localparam int INFO_FRAME_MAX_PB = 27;

    localparam int HB_TYPE_W    = 7;
    localparam int HB_VERSION_W = 8;
    localparam int HB_LENGTH_W  = 5;

    localparam logic [HB_TYPE_W-1:0] TYPE_VENDOR = 7'd1;
    localparam logic [HB_TYPE_W-1:0] TYPE_AVI    = 7'd2;
    localparam logic [HB_TYPE_W-1:0] TYPE_SPD    = 7'd3;
    localparam logic [HB_TYPE_W-1:0] TYPE_AUDIO  = 7'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUM     = 2'd1,
        PENDING = 2'd2
    } frame_state_e;

endpackage

// File: rtl/info_frame_checksum_accumulator.sv
// Sequential 8-bit byte accumulator: seeded on start, one byte per step,
// and on the last step the two's-complement checksum is registered.
module info_frame_checksum_accumulator (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       step,
    input  logic       last,
    input  logic [7:0] byte_in,
    output logic [7:0] checksum,
    output logic       done
);

    logic [7:0] acc;
    logic [7:0] acc_next;

    assign acc_next = acc + byte_in;
    assign done     = step & last;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acc      <= 8'd0;
            checksum <= 8'd0;
        end else begin
            if (start) begin
                acc <= seed;
            end else if (step) begin
                acc <= acc_next;
            end
            // Finalize folds in the last byte so no extra cycle is spent.
            if (done) begin
                checksum <= ~acc_next + 8'd1;
            end
        end
    end

endmodule

// File: rtl/info_frame_builder.sv
// Generic double-buffered HDMI InfoFrame generator: a control agent fills a shadow
// payload, commits it, and the frame goes live only at a scheduler-approved boundary.
module info_frame_builder
    import info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE       = 7'd3,
    parameter logic [7:0] VERSION    = 8'd1,
    parameter logic [4:0] MAX_LENGTH = 5'd27
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [4:0]       length,
    input  logic             commit,
    input  logic             swap_enable,
    output logic             busy,
    output logic             valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SUM     = SUM;
    localparam logic [1:0] ST_PENDING = PENDING;

    logic [1:0] state;
    logic [7:0] shadow    [0:31];
    logic [7:0] active_pb [0:INFO_FRAME_MAX_PB];
    logic [4:0] len;
    logic [4:0] len_in;
    logic [4:0] active_length;
    logic [4:0] idx;
    logic [7:0] seed;
    logic [7:0] sum_byte;
    logic [7:0] checksum;
    logic       acc_done;
    logic       in_idle;

    assign in_idle = (state == ST_IDLE);
    assign busy    = ~in_idle;

    always_comb begin
        len_in = length;
        if (length == 5'd0) begin
            len_in = 5'd1;
        end else if (length > MAX_LENGTH) begin
            len_in = MAX_LENGTH;
        end
    end

    assign seed     = {1'b1, TYPE} + VERSION + {3'b000, len_in};
    assign sum_byte = (idx <= len) ? shadow[idx] : 8'd0;

    info_frame_checksum_accumulator u_acc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .start     (in_idle & commit),
        .seed      (seed),
        .step      (state == ST_SUM),
        .last      (idx == MAX_LENGTH),
        .byte_in   (sum_byte),
        .checksum  (checksum),
        .done      (acc_done)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= 5'd0;
            len           <= 5'd0;
            active_length <= 5'd0;
            valid         <= 1'b0;
            for (int k = 0; k < 32; k++) begin
                shadow[k] <= 8'd0;
            end
            for (int k = 0; k <= INFO_FRAME_MAX_PB; k++) begin
                active_pb[k] <= 8'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // A write in the commit cycle still lands before summing starts.
                    if (wr_en && (wr_addr != 5'd0) && (wr_addr <= MAX_LENGTH)) begin
                        shadow[wr_addr] <= wr_data;
                    end
                    if (commit) begin
                        len   <= len_in;
                        idx   <= 5'd1;
                        state <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    idx <= idx + 5'd1;
                    if (acc_done) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (swap_enable) begin
                        for (int k = 1; k <= INFO_FRAME_MAX_PB; k++) begin
                            active_pb[k] <= (5'(k) <= len) ? shadow[k] : 8'd0;
                        end
                        active_pb[0]  <= checksum;
                        active_length <= len;
                        valid         <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign header = {3'b000, active_length, VERSION, 1'b1, TYPE};

    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sub[i][8*j +: 8] = active_pb[7*i + j];
            end
        end
    end

endmodule

// File: tb/tb_info_frame_builder.sv
// Bench for info_frame_builder: three parameterizations share one stimulus stream
// and are checked every cycle against a frame-level model, plus literal anchors.
module tb_info_frame_builder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic [4:0] length = 5'd0;
    logic       commit = 1'b0;
    logic       swap_enable = 1'b0;

    logic             busy_a, busy_b, busy_c;
    logic             valid_a, valid_b, valid_c;
    logic [23:0]      header_a, header_b, header_c;
    logic [3:0][55:0] sub_a, sub_b, sub_c;

    int total = 0;
    int bad = 0;

    info_frame_builder #(.TYPE(7'd3), .VERSION(8'd1), .MAX_LENGTH(5'd27)) dut_a (
        .clk_pixel(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .commit(commit), .swap_enable(swap_enable),
        .busy(busy_a), .valid(valid_a), .header(header_a), .sub(sub_a));

    info_frame_builder #(.TYPE(7'd2), .VERSION(8'd2), .MAX_LENGTH(5'd27)) dut_b (
        .clk_pixel(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .commit(commit), .swap_enable(swap_enable),
        .busy(busy_b), .valid(valid_b), .header(header_b), .sub(sub_b));

    info_frame_builder #(.TYPE(7'd4), .VERSION(8'd1), .MAX_LENGTH(5'd10)) dut_c (
        .clk_pixel(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .commit(commit), .swap_enable(swap_enable),
        .busy(busy_c), .valid(valid_c), .header(header_c), .sub(sub_c));

    function automatic logic [6:0] p_type(int i);
        case (i)
            0: return 7'd3;
            1: return 7'd2;
            default: return 7'd4;
        endcase
    endfunction

    function automatic logic [7:0] p_ver(int i);
        return (i == 1) ? 8'd2 : 8'd1;
    endfunction

    function automatic int p_max(int i);
        return (i == 2) ? 10 : 27;
    endfunction

    // Frame-level model: shadow bytes, the frame computed at commit, and the live frame.
    logic [7:0] m_shadow [3][32];
    logic [7:0] m_act    [3][28];
    logic [7:0] m_pend   [3][28];
    int         m_len [3];
    int         m_pend_len [3];
    int         m_left [3];
    bit         m_busy [3];
    bit         m_valid [3];
    bit         m_ready = 1'b0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(int i);
        int mx, l, s;
        mx = p_max(i);
        if (reset) begin
            for (int k = 0; k < 32; k++) m_shadow[i][k] = 8'd0;
            for (int k = 0; k < 28; k++) m_act[i][k] = 8'd0;
            m_len[i] = 0; m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_left[i] = 0;
        end else if (!m_busy[i]) begin
            if (wr_en && wr_addr >= 5'd1 && int'(wr_addr) <= mx)
                m_shadow[i][wr_addr] = wr_data;
            if (commit) begin
                l = (length == 5'd0) ? 1 : ((int'(length) > mx) ? mx : int'(length));
                s = 128 + int'(p_type(i)) + int'(p_ver(i)) + l;
                for (int k = 1; k <= l; k++) s += int'(m_shadow[i][k]);
                m_pend[i][0] = 8'((256 - (s % 256)) % 256);
                for (int k = 1; k < 28; k++) m_pend[i][k] = (k <= l) ? m_shadow[i][k] : 8'd0;
                m_pend_len[i] = l;
                m_busy[i] = 1'b1;
                m_left[i] = mx;
            end
        end else if (m_left[i] > 0) begin
            m_left[i]--;
        end else if (swap_enable) begin
            for (int k = 0; k < 28; k++) m_act[i][k] = m_pend[i][k];
            m_len[i] = m_pend_len[i];
            m_valid[i] = 1'b1;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_dut(int i, logic bsy, logic vld, logic [23:0] hdr, logic [3:0][55:0] sb);
        logic [23:0]      eh;
        logic [3:0][55:0] es;
        int s;
        eh = {3'b000, 5'(m_len[i]), p_ver(i), 1'b1, p_type(i)};
        for (int q = 0; q < 4; q++)
            for (int j = 0; j < 7; j++)
                es[q][8*j +: 8] = m_act[i][7*q + j];
        chk($sformatf("u%0d_busy", i), bsy, m_busy[i]);
        chk($sformatf("u%0d_valid", i), vld, m_valid[i]);
        chk($sformatf("u%0d_header", i), hdr, eh);
        chk($sformatf("u%0d_sub", i), sb, es);
        if (vld) begin
            s = int'(hdr[7:0]) + int'(hdr[15:8]) + int'(hdr[23:16]);
            for (int q = 0; q < 4; q++)
                for (int j = 0; j < 7; j++)
                    s += int'(sb[q][8*j +: 8]);
            chk($sformatf("u%0d_bytesum", i), s % 256, 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
            if (reset) m_ready = 1'b1;
            #1;
            if (m_ready) begin
                check_dut(0, busy_a, valid_a, header_a, sub_a);
                check_dut(1, busy_b, valid_b, header_b, sub_b);
                check_dut(2, busy_c, valid_c, header_c, sub_c);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((busy_a || busy_b || busy_c) && n < 300) begin
            n++;
            tick();
        end
        chk(name, busy_a | busy_b | busy_c, 1'b0);
    endtask

    logic [23:0]      old_hdr;
    logic [3:0][55:0] old_sub;
    int               nbusy;

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_header", header_a, 24'h000183);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_sub", sub_a, '0);

        // 1: single byte, length 25, swap held high
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h41; tick();
        wr_en = 1'b0; length = 5'd25; commit = 1'b1; swap_enable = 1'b1; tick();
        commit = 1'b0;
        nbusy = 0;
        while (busy_a && nbusy < 200) begin nbusy++; tick(); end
        chk("t1_busy_cycles", nbusy, 28);
        chk("t1_header", header_a, 24'h190183);
        chk("t1_pb0", sub_a[0][7:0], 8'h22);
        chk("t1_model_pb0", m_act[0][0], 8'h22);
        chk("t1_pb1", sub_a[0][15:8], 8'h41);
        chk("t1_valid", valid_a, 1'b1);
        wait_idle("t1_idle");

        // 2: all-zero payload on the AVI instance
        reset = 1'b1; tick(); reset = 1'b0;
        length = 5'd13; commit = 1'b1; tick(); commit = 1'b0;
        wait_idle("t2_idle");
        chk("t2_header", header_b, 24'h0D0282);
        chk("t2_pb0", sub_b[0][7:0], 8'h6F);
        chk("t2_model_pb0", m_act[1][0], 8'h6F);

        // 3: byte beyond length must not enter checksum or output
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'hFF; tick();
        wr_en = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
        wait_idle("t3_idle");
        chk("t3_pb0", sub_b[0][7:0], 8'h6F);
        chk("t3_pb20", sub_b[2][55:48], 8'h00);

        // 4: swap withheld; pending state ignores writes and commits
        swap_enable = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h5A; tick();
        wr_en = 1'b0; length = 5'd20; commit = 1'b1; tick();
        old_hdr = header_a; old_sub = sub_a;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h77; length = 5'd3;
        repeat (127) tick();
        chk("t4_busy_hold", busy_a, 1'b1);
        chk("t4_header_hold", header_a, old_hdr);
        chk("t4_sub_hold", sub_a, old_sub);
        wr_en = 1'b0; commit = 1'b0; swap_enable = 1'b1; tick();
        chk("t4_busy_after", busy_a, 1'b0);
        chk("t4_header", header_a, 24'h140183);
        chk("t4_pb0", sub_a[0][7:0], 8'h0F);
        chk("t4_pb3", sub_a[0][31:24], 8'h5A);
        chk("t4_pb5", sub_a[0][47:40], 8'h00);
        chk("t4_pb20", sub_a[2][55:48], 8'hFF);

        // 5: reset during SUM aborts, then a fresh commit completes
        length = 5'd10; commit = 1'b1; tick(); commit = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_valid", valid_a, 1'b0);
        chk("t5_sub", sub_a, '0);
        chk("t5_header", header_a, 24'h000183);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'h33; tick();
        wr_en = 1'b0; length = 5'd2; commit = 1'b1; tick(); commit = 1'b0;
        wait_idle("t5_idle");
        chk("t5_new_header", header_a, 24'h020183);
        chk("t5_new_pb2", sub_a[0][23:16], 8'h33);
        chk("t5_new_pb0", sub_a[0][7:0], 8'h47);

        // 6: write and commit in the same cycle
        reset = 1'b1; tick(); reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h10; length = 5'd1; commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        wait_idle("t6_idle");
        chk("t6_header", header_a, 24'h010183);
        chk("t6_pb1", sub_a[0][15:8], 8'h10);
        chk("t6_pb0", sub_a[0][7:0], 8'h6B);
        chk("t6_model_pb0", m_act[0][0], 8'h6B);

        // Randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(999) == 0);
            wr_en       = 1'($urandom_range(1));
            wr_addr     = 5'($urandom_range(31));
            wr_data     = 8'($urandom);
            length      = 5'($urandom_range(31));
            commit      = ($urandom_range(15) == 0);
            swap_enable = ($urandom_range(3) == 0);
            tick();
        end
        reset = 1'b0; wr_en = 1'b0; commit = 1'b0; swap_enable = 1'b1;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
